mxint8_to_float32_serializer: RTL

MXINT8_TO_FLOAT32_SERIALIZER -- requirements
Module: mxint8_to_float32_serializer

---
 rtl/mxint8_to_float32_serializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mxint8_to_float32_serializer.sv
// Accepts one MXINT8 block (shared E8M0 scale + BLOCK_SIZE elements) and emits it
// as a stream of IEEE-754 binary32 values, one per handshake. Optional: MXINT8_SUBNORMAL_EN.
module mxint8_to_float32_serializer #(
  parameter int BLOCK_SIZE           = 32,
  parameter int SCALE_WIDTH          = 8,
  parameter int MXINT8_ELEMENT_WIDTH = 8,
  parameter int FLOAT32_WIDTH        = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [SCALE_WIDTH-1:0]          i_scale,
  input  logic [MXINT8_ELEMENT_WIDTH-1:0] i_mxint8_elements [BLOCK_SIZE],
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [FLOAT32_WIDTH-1:0]        o_float32,
  output logic [$clog2(BLOCK_SIZE)-1:0]   o_index,
  output logic                            o_last
);

  localparam int IDX_W  = $clog2(BLOCK_SIZE);
  localparam int EW     = MXINT8_ELEMENT_WIDTH;
  localparam int SW     = SCALE_WIDTH;
  localparam int PW     = $clog2(EW);
  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(BLOCK_SIZE - 1);
  localparam logic signed [SW+1:0] FRAC_BITS = (SW + 2)'(EW - 2);
  localparam logic signed [SW+1:0] EXP_MAX   = (SW + 2)'(255);
  localparam logic signed [SW+1:0] EXP_ZERO  = '0;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, next_state;
  logic [EW-1:0] blk [BLOCK_SIZE];
  logic [SW-1:0] blk_scale;
  logic          accept;
  logic          last_hs;
  logic [IDX_W-1:0] next_idx;

  // Exact MXINT8 -> binary32: value = element / 2^(EW-2) * 2^(scale-127).
  function automatic logic [FLOAT32_WIDTH-1:0] convert(input logic [EW-1:0] elem,
                                                       input logic [SW-1:0] scale);
    logic                 sign;
    logic [EW-1:0]        m;
    logic [PW-1:0]        p;
    logic signed [SW+1:0] e;
    logic [MANT_W-1:0]    mant;
    sign = elem[EW-1];
    m    = sign ? (~elem + EW'(1)) : elem;
    p    = '0;
    for (int i = 0; i < EW; i++) begin
      if (m[i]) p = PW'(i);
    end
    e    = $signed({2'b00, scale} + {{(SW + 2 - PW){1'b0}}, p}) - FRAC_BITS;
    mant = MANT_W'({{MANT_W{1'b0}}, m} << (MANT_W - int'(p)));
    if (&scale)
      convert = 32'h7FC0_0000;
    else if (elem == '0)
      convert = '0;
    else if (e >= EXP_MAX)
      convert = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    else if (e <= EXP_ZERO)
`ifdef MXINT8_SUBNORMAL_EN
      // Shift is at most 22 here because E<=0 bounds both scale and m.
      convert = {sign, {EXP_W{1'b0}},
                 MANT_W'({{MANT_W{1'b0}}, m} << (int'(scale) + MANT_W - 1 - (EW - 2)))};
`else
      convert = {sign, {(FLOAT32_WIDTH - 1){1'b0}}};
`endif
    else
      convert = {sign, e[EXP_W-1:0], mant};
  endfunction

  assign last_hs  = o_valid && o_last && i_ready;
  assign accept   = i_valid && o_ready;
  assign next_idx = o_index + IDX_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = STREAM;
      STREAM:  if (last_hs && !accept) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    if (i_rst_n) o_ready = (state == IDLE) || last_hs;
  end

  // NOTE: the block store is cleared on reset because a stale block must never leak out.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BLOCK_SIZE; i++) blk[i] <= '0;
      blk_scale <= '0;
      o_valid   <= 1'b0;
      o_float32 <= '0;
      o_index   <= '0;
      o_last    <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < BLOCK_SIZE; i++) blk[i] <= i_mxint8_elements[i];
      blk_scale <= i_scale;
      o_valid   <= 1'b1;
      o_float32 <= convert(i_mxint8_elements[0], i_scale);
      o_index   <= '0;
      o_last    <= (BLOCK_SIZE == 1);
    end else if (o_valid && i_ready) begin
      if (o_last) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end else begin
        o_float32 <= convert(blk[next_idx], blk_scale);
        o_index   <= next_idx;
        o_last    <= (next_idx == LAST_IDX);
      end
    end
  end

endmodule
